instr_mem_loader: RTL and testbench

- Program memory stage directly upstream of the control unit. It is loaded word-by-word over a valid/ready loader port, then serves registered instruction fetches.
- The control unit's `addr` and `mem_en` drive the read port. `data_frame` is delivered one clock later and is valid throughout the control unit's Execute state.
- It masks reads of unloaded locations and flags them.

---
 rtl/instr_pkg.sv | 34 +++
 rtl/imem_array.sv | 36 +++
 rtl/instr_mem_loader.sv | 138 +++++++++++++
 tb/tb_instr_mem_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
//------------------------------------------------------------------------------
// Module   : instr_pkg
// Purpose  : Shared sizing, instruction field layout and FSM encodings for the
//            instruction memory loader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package instr_pkg;

  localparam int INSTR_W = 13;
  localparam int DEPTH   = 8;
  localparam int AW      = 3;

  // Instruction layout: A[12:9], B[8:5], Cin[4], opcode[3:0]
  localparam int A_MSB   = 12;
  localparam int A_LSB   = 9;
  localparam int B_MSB   = 8;
  localparam int B_LSB   = 5;
  localparam int CIN_BIT = 4;
  localparam int OP_MSB  = 3;
  localparam int OP_LSB  = 0;

  localparam logic [INSTR_W-1:0] NOP_FRAME = 13'h0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_LOAD  = 2'b01,
    ST_READY = 2'b10
  } ld_state_t;

endpackage : instr_pkg

`default_nettype wire

// File: rtl/imem_array.sv
//------------------------------------------------------------------------------
// Module   : imem_array
// Purpose  : DEPTH x WIDTH register file, one synchronous write port and one
//            asynchronous read port. Contents are intentionally not reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_array
  import instr_pkg::*;
#(
  parameter int DEPTH = instr_pkg::DEPTH,
  parameter int WIDTH = instr_pkg::INSTR_W,
  parameter int AW    = instr_pkg::AW
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : imem_array

`default_nettype wire

// File: rtl/instr_mem_loader.sv
//------------------------------------------------------------------------------
// Module   : instr_mem_loader
// Purpose  : Program memory loaded over a valid/ready port, serving registered
//            fetches that are masked (NOP + rd_miss) outside the loaded range.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_mem_loader
  import instr_pkg::*;
#(
  parameter int DEPTH = instr_pkg::DEPTH,
  parameter int WIDTH = instr_pkg::INSTR_W,
  parameter int AW    = instr_pkg::AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_start,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  input  logic [AW-1:0]    addr,
  input  logic             mem_en,
  output logic [WIDTH-1:0] data_frame,
  output logic             rd_miss,
  output logic             prog_ready,
  output logic [AW:0]      prog_len
);

  ld_state_t        r_state;
  ld_state_t        w_state_nxt;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    w_wptr_nxt;
  logic [AW:0]      r_prog_len;
  logic [AW:0]      w_prog_len_nxt;
  logic [WIDTH-1:0] r_data_frame;
  logic             r_rd_miss;

  logic             w_ld_ready;
  logic             w_xfer;
  logic             w_final;
  logic             w_hit;
  logic [WIDTH-1:0] w_rdata;

  assign w_ld_ready = (r_state == ST_LOAD) && !ld_start;
  assign w_xfer     = ld_valid && w_ld_ready;
  assign w_final    = ld_last || (r_wptr == AW'(DEPTH - 1));
  assign w_hit      = (r_state == ST_READY) && ({1'b0, addr} < r_prog_len);

  imem_array #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_imem_array (
    .clk     (clk),
    .i_we    (w_xfer),
    .i_waddr (r_wptr),
    .i_wdata (ld_data),
    .i_raddr (addr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_EMPTY;
      r_wptr     <= '0;
      r_prog_len <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wptr     <= w_wptr_nxt;
      r_prog_len <= w_prog_len_nxt;
    end
  end

  // ld_start wins over any transfer: a restart drops the word presented with it
  always_comb begin
    w_state_nxt    = r_state;
    w_wptr_nxt     = r_wptr;
    w_prog_len_nxt = r_prog_len;
    case (r_state)
      ST_EMPTY: begin
        if (ld_start) begin
          w_state_nxt    = ST_LOAD;
          w_wptr_nxt     = '0;
          w_prog_len_nxt = '0;
        end
      end
      ST_LOAD: begin
        if (ld_start) begin
          w_wptr_nxt     = '0;
          w_prog_len_nxt = '0;
        end else if (w_xfer) begin
          w_wptr_nxt = r_wptr + AW'(1);
          if (w_final) begin
            w_state_nxt    = ST_READY;
            w_prog_len_nxt = (AW+1)'(r_wptr) + (AW+1)'(1);
          end
        end
      end
      ST_READY: begin
        if (ld_start) begin
          w_state_nxt    = ST_LOAD;
          w_wptr_nxt     = '0;
          w_prog_len_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = ST_EMPTY;
        w_wptr_nxt     = '0;
        w_prog_len_nxt = '0;
      end
    endcase
  end

  // Fetch is checked against the current (pre-edge) program, so a fetch
  // coinciding with ld_start still sees the old contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_frame <= '0;
      r_rd_miss    <= 1'b0;
    end else if (mem_en) begin
      r_data_frame <= w_hit ? w_rdata : WIDTH'(NOP_FRAME);
      r_rd_miss    <= !w_hit;
    end else begin
      r_rd_miss    <= 1'b0;
    end
  end

  assign ld_ready   = w_ld_ready;
  assign data_frame = r_data_frame;
  assign rd_miss    = r_rd_miss;
  assign prog_ready = (r_state == ST_READY);
  assign prog_len   = r_prog_len;

endmodule : instr_mem_loader

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_instr_mem_loader
// Purpose  : Directed self-checking bench for instr_mem_loader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_mem_loader;

  localparam int DEPTH = 8;
  localparam int WIDTH = 13;
  localparam int AW    = 3;

  logic             clk;
  logic             reset;
  logic             ld_start;
  logic             ld_valid;
  logic [WIDTH-1:0] ld_data;
  logic             ld_last;
  logic             ld_ready;
  logic [AW-1:0]    addr;
  logic             mem_en;
  logic [WIDTH-1:0] data_frame;
  logic             rd_miss;
  logic             prog_ready;
  logic [AW:0]      prog_len;

  int n_checks = 0;
  int n_fails  = 0;

  instr_mem_loader #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .addr       (addr),
    .mem_en     (mem_en),
    .data_frame (data_frame),
    .rd_miss    (rd_miss),
    .prog_ready (prog_ready),
    .prog_len   (prog_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic last, input string tag);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    #1;
    chk(tag, 32'(ld_ready), 32'h1);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    mem_en = 1'b1;
    addr   = a;
    tick();
    mem_en = 1'b0;
  endtask

  task automatic start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    addr     = '0;
    mem_en   = 1'b0;

    tick();
    tick();
    chk("rst_prog_len", 32'(prog_len), 32'h0);
    chk("rst_ld_ready", 32'(ld_ready), 32'h0);
    reset = 1'b1;

    // Fetch from an empty memory
    fetch(3'd0);
    chk("empty_frame", 32'(data_frame), 32'h0);
    chk("empty_miss", 32'(rd_miss), 32'h1);
    chk("empty_prog_ready", 32'(prog_ready), 32'h0);
    chk("empty_ld_ready", 32'(ld_ready), 32'h0);
    chk("empty_prog_len", 32'(prog_len), 32'h0);

    // Six-word program terminated by ld_last
    start();
    for (int i = 1; i <= 6; i++) begin
      send(13'h1000 + 13'(i), (i == 6), "load6_ld_ready");
    end
    chk("load6_prog_ready", 32'(prog_ready), 32'h1);
    chk("load6_prog_len", 32'(prog_len), 32'h6);
    ld_valid = 1'b1;
    #1;
    chk("ready_ld_ready", 32'(ld_ready), 32'h0);
    ld_valid = 1'b0;

    fetch(3'd3);
    chk("fetch3_frame", 32'(data_frame), 32'h1004);
    chk("fetch3_miss", 32'(rd_miss), 32'h0);

    // Boundary: addr == prog_len is masked
    fetch(3'd6);
    chk("fetch6_frame", 32'(data_frame), 32'h0);
    chk("fetch6_miss", 32'(rd_miss), 32'h1);
    tick();
    chk("idle_miss_clear", 32'(rd_miss), 32'h0);
    chk("idle_frame_hold", 32'(data_frame), 32'h0);
    fetch(3'd5);
    chk("fetch5_frame", 32'(data_frame), 32'h1006);
    chk("fetch5_miss", 32'(rd_miss), 32'h0);
    tick();
    chk("hold_after_hit", 32'(data_frame), 32'h1006);

    // Fetch coinciding with ld_start is served from the old program
    ld_start = 1'b1;
    mem_en   = 1'b1;
    addr     = 3'd2;
    tick();
    ld_start = 1'b0;
    chk("same_cyc_frame", 32'(data_frame), 32'h1003);
    chk("same_cyc_miss", 32'(rd_miss), 32'h0);
    chk("same_cyc_prog_ready", 32'(prog_ready), 32'h0);
    chk("same_cyc_prog_len", 32'(prog_len), 32'h0);
    tick();
    mem_en = 1'b0;
    chk("load_fetch_frame", 32'(data_frame), 32'h0);
    chk("load_fetch_miss", 32'(rd_miss), 32'h1);

    // Restart with a word presented alongside: that word is dropped
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 13'h1FFF;
    #1;
    chk("restart_ld_ready", 32'(ld_ready), 32'h0);
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;

    // Full eight-word program, no ld_last
    for (int i = 0; i < 8; i++) begin
      send(13'h0100 + 13'(i), 1'b0, "load8_ld_ready");
    end
    chk("load8_prog_ready", 32'(prog_ready), 32'h1);
    chk("load8_prog_len", 32'(prog_len), 32'h8);
    fetch(3'd7);
    chk("fetch7_frame", 32'(data_frame), 32'h0107);
    fetch(3'd0);
    chk("fetch0_frame", 32'(data_frame), 32'h0100);

    // Asynchronous reset in the middle of a load
    start();
    for (int i = 1; i <= 3; i++) begin
      send(13'h0200 + 13'(i), 1'b0, "midload_ld_ready");
    end
    #2;
    reset = 1'b0;
    #1;
    chk("abort_prog_len", 32'(prog_len), 32'h0);
    chk("abort_ld_ready", 32'(ld_ready), 32'h0);
    chk("abort_prog_ready", 32'(prog_ready), 32'h0);
    tick();
    reset = 1'b1;
    ld_valid = 1'b1;
    #1;
    chk("abort_no_load", 32'(ld_ready), 32'h0);
    tick();
    ld_valid = 1'b0;

    start();
    send(13'h0301, 1'b0, "reload_ld_ready");
    send(13'h0302, 1'b1, "reload_ld_ready");
    chk("reload_prog_len", 32'(prog_len), 32'h2);
    fetch(3'd0);
    chk("reload_fetch0", 32'(data_frame), 32'h0301);
    fetch(3'd2);
    chk("reload_masked_frame", 32'(data_frame), 32'h0);
    chk("reload_masked_miss", 32'(rd_miss), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule : tb_instr_mem_loader

`default_nettype wire
